// File: rtl/ads1115_target.sv
// ads1115_target: ADS1115-style I2C target; filtered i_scl/i_sda in, open-drain o_sda, conversion/config/alert fabric ports
module ads1115_target #(
  parameter logic [6:0] ADDR = 7'h48,
  parameter int FILTER_LEN = 3,
  parameter int ALERT_CYCLES = 200
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda,
  input  logic [15:0] i_conv_data,
  input  logic        i_conv_valid,
  output logic        o_alert_n,
  output logic [15:0] o_config,
  output logic        o_config_wr,
  output logic        o_busy
);
  localparam int AW = $clog2(ALERT_CYCLES + 1);
  localparam logic [3:0] IDLE = 4'd0, ADDR_S = 4'd1, ADDR_ACK = 4'd2, PTR = 4'd3, PTR_ACK = 4'd4;
  localparam logic [3:0] WR_BYTE = 4'd5, WR_ACK = 4'd6, RD_BYTE = 4'd7, RD_ACK = 4'd8, IGNORE = 4'd9;
  logic [1:0] pins, f, fq;
  logic [3:0] state, bit_cnt;
  logic [7:0] sr, msb;
  logic [1:0] ptr;
  logic [15:0] shadow, conv, lo_th, hi_th, sel;
  logic [14:0] cfg;
  logic [AW-1:0] acnt;
  logic second, ack, scl, sda, rise, fall, start, stop;
  assign pins = {i_sda, i_scl};
  for (genvar g = 0; g < 2; g++) begin : g_flt
    logic a, b, lv;
    logic [3:0] c;
    always_ff @(posedge i_clk)
      if (!i_rst_n) begin
        a <= 1'b1;
        b <= 1'b1;
        lv <= 1'b1;
        c <= 4'd0;
      end else begin
        a <= pins[g];
        b <= a;
        c <= (b != lv && c != 4'(FILTER_LEN - 1)) ? c + 4'd1 : 4'd0;
        if (b != lv && c == 4'(FILTER_LEN - 1)) lv <= b;
      end
    assign f[g] = lv;
  end
  assign scl = f[0];
  assign sda = f[1];
  assign rise = scl & ~fq[0];
  assign fall = ~scl & fq[0];
  assign start = scl & fq[0] & fq[1] & ~sda;
  assign stop = scl & fq[0] & ~fq[1] & sda;
  assign sel = ptr == 2'd0 ? conv : ptr == 2'd1 ? {1'b1, cfg} : ptr == 2'd2 ? lo_th : hi_th;
  assign o_config = {1'b1, cfg};
  assign o_alert_n = acnt == '0;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      fq <= 2'b11;
      state <= IDLE;
      bit_cnt <= 4'd0;
      sr <= 8'd0;
      msb <= 8'd0;
      ptr <= 2'd0;
      second <= 1'b0;
      ack <= 1'b1;
      shadow <= 16'd0;
      conv <= 16'h0000;
      cfg <= 15'h0583;
      lo_th <= 16'h8000;
      hi_th <= 16'h7FFF;
      acnt <= '0;
      o_sda <= 1'b1;
      o_busy <= 1'b0;
      o_config_wr <= 1'b0;
    end else begin
      fq <= f;
      o_config_wr <= 1'b0;
      if (i_conv_valid) conv <= i_conv_data;
      acnt <= (i_conv_valid && hi_th[15] && !lo_th[15]) ? AW'(ALERT_CYCLES) : acnt - AW'(acnt != '0);
      if (start || stop) begin
        state <= start ? ADDR_S : IDLE;
        bit_cnt <= 4'd0;
        o_sda <= 1'b1;
        o_busy <= 1'b0;
      end else if (rise) begin
        if (state == ADDR_S || state == PTR || state == WR_BYTE) begin
          sr <= {sr[6:0], sda};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (state == RD_ACK) ack <= sda;
      end else if (fall) begin
        case (state)
          ADDR_S: if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            state <= sr[7:1] == ADDR ? ADDR_ACK : IGNORE;
            o_sda <= sr[7:1] != ADDR;
            o_busy <= sr[7:1] == ADDR;
          end
          ADDR_ACK: if (sr[0]) begin
            state <= RD_BYTE;
            shadow <= sel;
            sr <= {sel[14:8], 1'b1};
            o_sda <= sel[15];
            bit_cnt <= 4'd1;
            second <= 1'b0;
          end else begin
            state <= PTR;
            o_sda <= 1'b1;
          end
          PTR: if (bit_cnt == 4'd8) begin
            ptr <= sr[1:0];
            o_sda <= 1'b0;
            state <= PTR_ACK;
          end
          PTR_ACK: begin
            o_sda <= 1'b1;
            state <= WR_BYTE;
            bit_cnt <= 4'd0;
            second <= 1'b0;
          end
          WR_BYTE: if (bit_cnt == 4'd8) begin
            o_sda <= 1'b0;
            state <= WR_ACK;
            if (!second) msb <= sr;
          end
          WR_ACK: begin
            o_sda <= 1'b1;
            state <= WR_BYTE;
            bit_cnt <= 4'd0;
            second <= !second;
            if (second && ptr == 2'd1) begin
              cfg <= {msb[6:0], sr};
              o_config_wr <= 1'b1;
            end
            if (second && ptr == 2'd2) lo_th <= {msb, sr};
            if (second && ptr == 2'd3) hi_th <= {msb, sr};
          end
          RD_BYTE: if (bit_cnt == 4'd8) begin
            o_sda <= 1'b1;
            state <= RD_ACK;
          end else begin
            o_sda <= sr[7];
            sr <= {sr[6:0], 1'b1};
            bit_cnt <= bit_cnt + 4'd1;
          end
          RD_ACK: if (ack) begin
            state <= IGNORE;
            o_sda <= 1'b1;
          end else begin
            state <= RD_BYTE;
            bit_cnt <= 4'd1;
            second <= !second;
            if (second) shadow <= sel;
            o_sda <= second ? sel[15] : shadow[7];
            sr <= second ? {sel[14:8], 1'b1} : {shadow[6:0], 1'b1};
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_ads1115_target.sv
// tb_ads1115_target: scoreboard bench driving an I2C master model against ads1115_target
module tb_ads1115_target;
  localparam int H = 20;
  logic clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1, conv_valid = 1'b0, glitch = 1'b0;
  logic [15:0] conv_data = 16'd0;
  logic sda, alert_n, config_wr, busy, sda_bus;
  logic [15:0] cfg;
  logic [15:0] sb_q[$];
  int n_cmp = 0, n_err = 0, wr_pulses = 0;
  assign sda_bus = m_sda & sda;
  always #5 clk = ~clk;
  ads1115_target dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(m_scl), .i_sda(sda_bus), .o_sda(sda),
    .i_conv_data(conv_data), .i_conv_valid(conv_valid), .o_alert_n(alert_n),
    .o_config(cfg), .o_config_wr(config_wr), .o_busy(busy)
  );
  always @(negedge clk) if (config_wr) wr_pulses++;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic sb_pop(input string tag, input logic [15:0] got);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %h expected <empty scoreboard>", tag, got);
    end else check(tag, got, sb_q.pop_front());
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_c;
    clks(H / 2); m_sda = 1'b1; clks(H / 2); m_scl = 1'b1; clks(H); m_sda = 1'b0; clks(H); m_scl = 1'b0;
  endtask
  task automatic stop_c;
    clks(H / 2); m_sda = 1'b0; clks(H / 2); m_scl = 1'b1; clks(H); m_sda = 1'b1; clks(H);
  endtask
  task automatic put_bit(input logic b);
    clks(H / 2);
    m_sda = b;
    if (glitch) begin
      clks(2); m_scl = 1'b1; clks(1); m_scl = 1'b0;
    end
    clks(H / 2); m_scl = 1'b1; clks(H); m_scl = 1'b0;
  endtask
  task automatic get_bit(output logic b);
    clks(H / 2); m_sda = 1'b1; clks(H / 2); m_scl = 1'b1; clks(H / 2); b = sda_bus; clks(H / 2); m_scl = 1'b0;
  endtask
  task automatic wr_byte(input logic [7:0] v, input logic exp_ack, input string tag);
    logic a;
    sb_q.push_back({15'd0, exp_ack});
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(a);
    sb_pop(tag, {15'd0, a});
  endtask
  task automatic rd_byte(input logic [7:0] exp, input logic nack, input string tag);
    logic [7:0] v;
    logic b;
    sb_q.push_back({8'd0, exp});
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(nack);
    sb_pop(tag, {8'd0, v});
  endtask
  task automatic wr_reg(input logic [1:0] p, input logic [15:0] v);
    start_c;
    wr_byte(8'h90, 1'b0, "wr_addr_ack");
    wr_byte({6'd0, p}, 1'b0, "wr_ptr_ack");
    wr_byte(v[15:8], 1'b0, "wr_msb_ack");
    wr_byte(v[7:0], 1'b0, "wr_lsb_ack");
    stop_c;
  endtask
  task automatic strobe(input logic [15:0] v);
    clks(1); conv_data = v; conv_valid = 1'b1; clks(1); conv_valid = 1'b0;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    clks(5); rst_n = 1'b1; clks(2);
    check("rst_sda", {15'd0, sda}, 16'd1);
    check("rst_alert", {15'd0, alert_n}, 16'd1);
    check("rst_config", cfg, 16'h8583);
    check("rst_config_wr", {15'd0, config_wr}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    strobe(16'h1234);
    clks(3);
    check("alert_not_ready", {15'd0, alert_n}, 16'd1);
    start_c;
    wr_byte(8'h90, 1'b0, "rd1_addr_w");
    wr_byte(8'h00, 1'b0, "rd1_ptr");
    stop_c;
    start_c;
    wr_byte(8'h91, 1'b0, "rd1_addr_r");
    check("busy_addressed", {15'd0, busy}, 16'd1);
    rd_byte(8'h12, 1'b0, "rd1_msb");
    rd_byte(8'h34, 1'b1, "rd1_lsb");
    clks(H / 2);
    check("sda_after_nack", {15'd0, sda}, 16'd1);
    stop_c;
    check("busy_after_stop", {15'd0, busy}, 16'd0);
    wr_reg(2'd1, 16'hC383);
    check("cfg_wr_pulses", wr_pulses[15:0], 16'd1);
    check("cfg_value", cfg, 16'hC383);
    start_c;
    wr_byte(8'h90, 1'b0, "cfg_rb_addr_w");
    wr_byte(8'h01, 1'b0, "cfg_rb_ptr");
    start_c;
    wr_byte(8'h91, 1'b0, "cfg_rb_addr_r");
    rd_byte(8'hC3, 1'b0, "cfg_rb_msb");
    rd_byte(8'h83, 1'b1, "cfg_rb_lsb");
    stop_c;
    wr_reg(2'd3, 16'h8000);
    wr_reg(2'd2, 16'h0000);
    strobe(16'h0BCD);
    check("alert_next_cycle", {15'd0, alert_n}, 16'd0);
    n = 0;
    while (alert_n == 1'b0 && n < 1000) begin
      n++;
      clks(1);
    end
    check("alert_width", n[15:0], 16'd200);
    wr_reg(2'd3, 16'h7FFF);
    wr_reg(2'd2, 16'h8000);
    strobe(16'h0BCE);
    n = 0;
    repeat (250) begin
      if (alert_n == 1'b0) n++;
      clks(1);
    end
    check("alert_off_lows", n[15:0], 16'd0);
    start_c;
    wr_byte(8'h92, 1'b1, "bad_addr_nack");
    check("bad_addr_busy", {15'd0, busy}, 16'd0);
    wr_byte(8'h01, 1'b1, "bad_ptr_nack");
    wr_byte(8'h00, 1'b1, "bad_msb_nack");
    wr_byte(8'h00, 1'b1, "bad_lsb_nack");
    stop_c;
    check("bad_cfg_kept", cfg, 16'hC383);
    check("bad_no_pulse", wr_pulses[15:0], 16'd1);
    strobe(16'hAAAA);
    start_c;
    wr_byte(8'h90, 1'b0, "tear_addr_w");
    wr_byte(8'h00, 1'b0, "tear_ptr");
    stop_c;
    start_c;
    wr_byte(8'h91, 1'b0, "tear_addr_r");
    rd_byte(8'hAA, 1'b0, "tear_msb");
    strobe(16'h5555);
    rd_byte(8'hAA, 1'b1, "tear_lsb");
    stop_c;
    start_c;
    wr_byte(8'h91, 1'b0, "tear2_addr_r");
    rd_byte(8'h55, 1'b0, "tear2_msb");
    rd_byte(8'h55, 1'b1, "tear2_lsb");
    stop_c;
    start_c;
    wr_byte(8'h90, 1'b0, "glitch_addr");
    wr_byte(8'h01, 1'b0, "glitch_ptr");
    glitch = 1'b1;
    wr_byte(8'h12, 1'b0, "glitch_msb");
    wr_byte(8'h34, 1'b0, "glitch_lsb");
    glitch = 1'b0;
    stop_c;
    check("glitch_cfg", cfg, 16'h9234);
    check("glitch_pulses", wr_pulses[15:0], 16'd2);
    start_c;
    wr_byte(8'h90, 1'b0, "abort_addr");
    wr_byte(8'h01, 1'b0, "abort_ptr");
    wr_byte(8'h55, 1'b0, "abort_msb");
    stop_c;
    check("abort_cfg", cfg, 16'h9234);
    check("abort_pulses", wr_pulses[15:0], 16'd2);
    start_c;
    wr_byte(8'h91, 1'b0, "rs_addr1");
    rd_byte(8'h92, 1'b1, "rs_msb1");
    start_c;
    wr_byte(8'h91, 1'b0, "rs_addr2");
    rd_byte(8'h92, 1'b0, "rs_msb2");
    rd_byte(8'h34, 1'b1, "rs_lsb2");
    stop_c;
    start_c;
    for (int i = 7; i >= 0; i--) put_bit(i == 4 || i == 7);
    clks(H / 2); m_sda = 1'b1; clks(H / 2);
    check("mid_ack_drive", {15'd0, sda}, 16'd0);
    rst_n = 1'b0;
    clks(1);
    check("mid_rst_sda", {15'd0, sda}, 16'd1);
    check("mid_rst_cfg", cfg, 16'h8583);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    m_scl = 1'b1;
    clks(2); rst_n = 1'b1; clks(H);
    check("sb_drained", sb_q.size() == 0 ? 16'd1 : 16'd0, 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
